// File: rtl/regfile_write_buffer.sv
// Write-side front end of the register file: queues (addr, data) writes in a
// small FIFO, drains one per cycle as a one-hot write enable, and bypasses pending data.
module regfile_write_buffer #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rf_stall,
  output logic [NUM_REGS-1:0]     rf_wen,
  output logic [WIDTH-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_hit,
  output logic [WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]   mem_addr_q [DEPTH];
  logic [WIDTH-1:0]    mem_data_q [DEPTH];

  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_REGS-1:0] rf_wen_q, rf_wen_d;
  logic [WIDTH-1:0]    rf_wdata_q, rf_wdata_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;

  logic push;
  logic pop;
  logic accept;

  // While reset is held the buffer advertises ready but nothing it sees is kept.
  assign wr_ready = !reset || (count_q < DEPTH_C);
  assign accept   = wr_valid && wr_ready && reset;
  assign push     = accept && (wr_addr != '0);
  assign pop      = (count_q != '0) && !rf_stall;

  assign rf_wen   = rf_wen_q;
  assign rf_wdata = rf_wdata_q;
  assign count    = count_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rf_wen_d   = '0;
    rf_wdata_d = rf_wdata_q;
    out_addr_d = out_addr_q;
    if (push) begin
      tail_d = tail_q + 1'b1;
    end
    if (pop) begin
      head_d     = head_q + 1'b1;
      rf_wen_d   = NUM_REGS'(1) << mem_addr_q[head_q];
      rf_wdata_d = mem_data_q[head_q];
      out_addr_d = mem_addr_q[head_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_wen_q   <= '0;
      rf_wdata_q <= '0;
      out_addr_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_wen_q   <= rf_wen_d;
      rf_wdata_q <= rf_wdata_d;
      out_addr_q <= out_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[tail_q] <= wr_addr;
      mem_data_q[tail_q] <= wr_data;
    end
  end

  // Scan oldest to newest so the youngest match overrides; the output stage is oldest of all.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    rd_hit  = 1'b0;
    rd_data = '0;
    if (rd_addr != '0) begin
      if ((rf_wen_q != '0) && (out_addr_q == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = rf_wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (mem_addr_q[idx] == rd_addr)) begin
          rd_hit  = 1'b1;
          rd_data = mem_data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed self-checking bench for regfile_write_buffer: reset, latency, stall/full,
// same-address ordering and bypass, address-0 drop, streaming, and mid-run reset.
module tb_regfile_write_buffer;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rf_stall;
  logic [31:0] rf_wen;
  logic [31:0] rf_wdata;
  logic [4:0]  rd_addr;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic [2:0]  count;

  int nChecks = 0;
  int nPassed = 0;

  regfile_write_buffer #(
    .WIDTH(32), .NUM_REGS(32), .ADDR_W(5), .DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rf_stall (rf_stall),
    .rf_wen   (rf_wen),
    .rf_wdata (rf_wdata),
    .rd_addr  (rd_addr),
    .rd_hit   (rd_hit),
    .rd_data  (rd_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [31:0] d,
                               input logic s, input logic [4:0] ra);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    rf_stall = s;
    rd_addr  = ra;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed === expected) nPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    // Reset state
    tick();
    tick();
    checkOutput("reset_ready", {31'd0, wr_ready}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("reset_count", {29'd0, count}, 32'd0);
    checkOutput("reset_wen", rf_wen, 32'd0);
    checkOutput("reset_wdata", rf_wdata, 32'd0);
    checkOutput("reset_rdy1", {31'd0, wr_ready}, 32'd1);

    // Single write latency
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    tick();
    checkOutput("t1_count_push", {29'd0, count}, 32'd1);
    checkOutput("t1_wen_idle", rf_wen, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd5);
    checkOutput("t1_byp_fifo", rd_data, 32'hDEADBEEF);
    tick();
    checkOutput("t1_wen", rf_wen, 32'h20);
    checkOutput("t1_wdata", rf_wdata, 32'hDEADBEEF);
    checkOutput("t1_count_drain", {29'd0, count}, 32'd0);
    tick();
    checkOutput("t1_wen_clear", rf_wen, 32'd0);
    checkOutput("t1_wdata_hold", rf_wdata, 32'hDEADBEEF);
    checkOutput("t1_nohit", {31'd0, rd_hit}, 32'd0);

    // Stall and fill
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'd0);
      tick();
    end
    checkOutput("t2_count_full", {29'd0, count}, 32'd4);
    checkOutput("t2_ready_full", {31'd0, wr_ready}, 32'd0);
    checkOutput("t2_wen_stall", rf_wen, 32'd0);
    applyStimulus(1'b1, 5'd9, 32'h999, 1'b1, 5'd0);
    tick();
    checkOutput("t2_fifth_held", {29'd0, count}, 32'd4);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput($sformatf("t2_wen%0d", i), rf_wen, 32'd1 << i);
      checkOutput($sformatf("t2_wdata%0d", i), rf_wdata, 32'h100 + 32'(i));
    end
    tick();
    checkOutput("t2_drained", {29'd0, count}, 32'd0);
    checkOutput("t2_wen_end", rf_wen, 32'd0);

    // Same-address ordering and bypass priority
    applyStimulus(1'b1, 5'd7, 32'hA, 1'b1, 5'd7);
    tick();
    applyStimulus(1'b1, 5'd7, 32'hB, 1'b1, 5'd7);
    checkOutput("t3_byp_one", rd_data, 32'hA);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    checkOutput("t3_hit", {31'd0, rd_hit}, 32'd1);
    checkOutput("t3_newest", rd_data, 32'hB);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    checkOutput("t3_miss_hit", {31'd0, rd_hit}, 32'd0);
    checkOutput("t3_miss_data", rd_data, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd7);
    tick();
    checkOutput("t3_wen_a", rf_wen, 32'h80);
    checkOutput("t3_wdata_a", rf_wdata, 32'hA);
    checkOutput("t3_fifo_beats_out", rd_data, 32'hB);
    tick();
    checkOutput("t3_wdata_b", rf_wdata, 32'hB);
    checkOutput("t3_out_hit", {31'd0, rd_hit}, 32'd1);
    checkOutput("t3_out_data", rd_data, 32'hB);
    tick();
    checkOutput("t3_out_gone", {31'd0, rd_hit}, 32'd0);

    // Address 0 is accepted and dropped
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0);
    checkOutput("t4_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    checkOutput("t4_count", {29'd0, count}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    tick();
    checkOutput("t4_wen", rf_wen, 32'd0);
    checkOutput("t4_rd0", {31'd0, rd_hit}, 32'd0);

    // Streaming, one write per cycle across pointer wrap
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 32'h1000 + 32'(i), 1'b0, 5'd0);
      tick();
      checkOutput($sformatf("t5_count%0d", i), {29'd0, count}, 32'd1);
      if (i > 0) begin
        checkOutput($sformatf("t5_wen%0d", i), rf_wen, 32'd1 << i);
        checkOutput($sformatf("t5_wdata%0d", i), rf_wdata, 32'h1000 + 32'(i - 1));
      end
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    tick();
    checkOutput("t5_wen_last", rf_wen, 32'd1 << 20);
    checkOutput("t5_count_end", {29'd0, count}, 32'd0);
    tick();

    // Reset while full
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(10 + i), 32'h2000 + 32'(i), 1'b1, 5'd0);
      tick();
    end
    checkOutput("t6_full", {29'd0, count}, 32'd4);
    reset = 1'b0;
    applyStimulus(1'b1, 5'd14, 32'h3000, 1'b0, 5'd10);
    checkOutput("t6_ready_in_reset", {31'd0, wr_ready}, 32'd1);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd10);
    checkOutput("t6_count", {29'd0, count}, 32'd0);
    checkOutput("t6_wen", rf_wen, 32'd0);
    checkOutput("t6_wdata", rf_wdata, 32'd0);
    checkOutput("t6_nohit", {31'd0, rd_hit}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t6_quiet%0d", i), rf_wen, 32'd0);
    end

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
